if_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS datapath. Holds the program counter and computes PC+4 with the shared 32-bit adder. Selects the next PC from sequential, branch, or jump sources, and drives the instruction-memory address. Captures the fetched instruction and PC+4 into the IF/ID pipeline register, which has stall (hold) and flush (bubble) control from the hazard unit.

---
 rtl/if_stage_if.sv | 10 +
 rtl/if_stage.sv | 79 +++++++
 tb/tb_if_stage.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   addr  : fetch address (driven by the fetch stage, equals its PC)
//   rdata : instruction word, combinational read of addr
interface if_stage_if;
  logic [31:0] addr;
  logic [31:0] rdata;

  modport master (output addr, input rdata);
  modport slave  (input addr, output rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, PC+4 adder, next-PC select and the
// IF/ID pipeline register with stall (hold) and flush (bubble) control.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   stall, flush          hazard-unit controls
//   branch_taken/target   branch redirect from ID
//   jump/jump_target      jump redirect from ID (wins over branch)
//   imem                  instruction-memory bus (addr out, rdata in)
//   pc                    current PC
//   ifid_instr/pc_plus4/valid   IF/ID register contents
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  input  logic              jump,
  input  logic [31:0]       jump_target,
  if_stage_if.master        imem,
  output logic [31:0]       pc,
  output logic [31:0]       ifid_instr,
  output logic [31:0]       ifid_pc_plus4,
  output logic              ifid_valid
);

  logic [31:0] pc_plus4;
  logic [31:0] target;
  logic [31:0] pc_next;
  logic        redirect;
  logic        ifid_bubble;

  assign imem.addr = pc;

  always_comb begin
    pc_plus4    = pc + 32'd4;
    redirect    = !stall && (jump || branch_taken);
    // Targets are forced word-aligned; jump has priority over branch.
    target      = jump ? (jump_target & 32'hFFFF_FFFC)
                       : (branch_target & 32'hFFFF_FFFC);
    pc_next     = pc_plus4;
    if (stall)
      pc_next = pc;
    else if (redirect)
      pc_next = target;
    // The word fetched during a redirect is on the wrong path.
    ifid_bubble = flush || redirect;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

  // Stall overrides flush and redirect; the hazard unit re-asserts them later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instr    <= NOP_INSTR;
      ifid_pc_plus4 <= 32'd0;
      ifid_valid    <= 1'b0;
    end else if (!stall) begin
      if (ifid_bubble) begin
        ifid_instr    <= NOP_INSTR;
        ifid_pc_plus4 <= 32'd0;
        ifid_valid    <= 1'b0;
      end else begin
        ifid_instr    <= imem.rdata;
        ifid_pc_plus4 <= pc_plus4;
        ifid_valid    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, branch_taken = 1'b0, jump = 1'b0;
  logic [31:0] branch_target = 32'd0, jump_target = 32'd0;
  logic [31:0] pc, ifid_instr, ifid_pc_plus4;
  logic        ifid_valid;

  logic [31:0] pc_w, ifid_instr_w, ifid_pc_plus4_w;
  logic        ifid_valid_w;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pp4;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pp4;
  logic        m_valid;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return (a >> 2) + 32'd1;
  endfunction

  if_stage_if imem_bus ();
  if_stage_if imem_bus_w ();
  assign imem_bus.rdata   = imem_word(imem_bus.addr);
  assign imem_bus_w.rdata = imem_word(imem_bus_w.addr);

  if_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .imem(imem_bus),
    .pc(pc), .ifid_instr(ifid_instr), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(1'b0), .flush(1'b0),
    .branch_taken(1'b0), .branch_target(32'd0),
    .jump(1'b0), .jump_target(32'd0), .imem(imem_bus_w),
    .pc(pc_w), .ifid_instr(ifid_instr_w), .ifid_pc_plus4(ifid_pc_plus4_w),
    .ifid_valid(ifid_valid_w)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_instr = NOP;
    m_pp4   = 32'd0;
    m_valid = 1'b0;
  endtask

  // Called while clk is low: drive inputs, predict the state after the next
  // rising edge, push it, then return at the following falling edge.
  task automatic step(input logic s, input logic f, input logic b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt);
    exp_t e;
    stall = s; flush = f; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt;
    if (!s) begin
      if (f || j || b) begin
        m_instr = NOP; m_pp4 = 32'd0; m_valid = 1'b0;
      end else begin
        m_instr = imem_word(m_pc); m_pp4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      if (j)      m_pc = {jt[31:2], 2'b00};
      else if (b) m_pc = {bt[31:2], 2'b00};
      else        m_pc = m_pc + 32'd4;
    end
    e.pc = m_pc; e.instr = m_instr; e.pp4 = m_pp4; e.valid = m_valid;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  // Monitor: compare DUT state against the oldest prediction after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", pc, e.pc);
      chk("imem_addr", imem_bus.addr, e.pc);
      chk("ifid_instr", ifid_instr, e.instr);
      chk("ifid_pc_plus4", ifid_pc_plus4, e.pp4);
      chk("ifid_valid", {31'd0, ifid_valid}, {31'd0, e.valid});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_imem_addr", imem_bus.addr, RST_PC);
    chk("rst_ifid_instr", ifid_instr, NOP);
    chk("rst_ifid_pc_plus4", ifid_pc_plus4, 32'd0);
    chk("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("wrap_rst_pc", pc_w, 32'hFFFF_FFFC);
    #1 rst_n = 1'b1;

    // Sequential fetch from reset; the wrap instance is checked after edge 1.
    idle(1);
    chk("wrap_pc", pc_w, 32'd0);
    chk("wrap_ifid_pc_plus4", ifid_pc_plus4_w, 32'd0);
    chk("wrap_ifid_valid", {31'd0, ifid_valid_w}, 32'd1);
    chk("wrap_ifid_instr", ifid_instr_w, imem_word(32'hFFFF_FFFC));
    idle(8);  // pc now 0x24

    // Asynchronous reset between edges.
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc, RST_PC);
    chk("async_rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("async_rst_ifid_instr", ifid_instr, NOP);
    model_reset();
    #1 rst_n = 1'b1;

    // Branch at pc=8.
    idle(2);
    step(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
    idle(3);

    // Stall dominates branch and flush for 3 edges.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 32'h80, 1'b0, 32'd0);
    idle(2);

    // Jump beats branch, target aligned.
    step(1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 32'h103);
    idle(2);

    // Plain flush.
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    idle(1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 6) == 0, 32'($urandom_range(0, 4095)),
           $urandom_range(0, 9) == 0, 32'($urandom_range(0, 4095)));
    end
    idle(1);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
